// File: rtl/burst.sv
// rtl/burst.sv - button-triggered pulse-train generator (burst clock)
module burst #(
    parameter int PULSES   = 10,
    parameter int HIGH_CYC = 1,
    parameter int LOW_CYC  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bRelease,
    output logic burstClk,
    output logic busy
);

    // Pulse counter must hold PULSES itself; keep at least one bit when bursts are disabled.
    localparam int PW   = (PULSES > 0) ? $clog2(PULSES + 1) : 1;
    localparam int PMAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int PHW  = $clog2(PMAX + 1);

    localparam logic [PW-1:0]  PULSE_LAST = PW'(PULSES);
    localparam logic [PHW-1:0] HIGH_LAST  = PHW'(HIGH_CYC - 1);
    localparam logic [PHW-1:0] LOW_LAST   = PHW'(LOW_CYC - 1);
    localparam logic           ENABLED    = (PULSES > 0);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t         state;
    logic [PW-1:0]  pulse_cnt;
    logic [PHW-1:0] phase;
    logic           s1, s2, s3;
    logic           rise;

    // Two-flop synchronizer plus history flop; reset to 0 so a level already high counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bRelease;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Burst sequencer: HIGH/LOW phases per pulse, outputs registered so burstClk is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pulse_cnt <= '0;
            phase     <= '0;
            burstClk  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    burstClk <= 1'b0;
                    busy     <= 1'b0;
                    if (rise && ENABLED) begin
                        state     <= HIGH;
                        pulse_cnt <= PW'(1);
                        phase     <= '0;
                        burstClk  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                HIGH: begin
                    if (phase == HIGH_LAST) begin
                        state    <= LOW;
                        phase    <= '0;
                        burstClk <= 1'b0;
                    end else begin
                        phase <= phase + PHW'(1);
                    end
                end
                LOW: begin
                    if (phase == LOW_LAST) begin
                        phase <= '0;
                        if (pulse_cnt == PULSE_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            pulse_cnt <= pulse_cnt + PW'(1);
                            state     <= HIGH;
                            burstClk  <= 1'b1;
                        end
                    end else begin
                        phase <= phase + PHW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    burstClk <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst.sv
// tb/tb_burst.sv - directed self-checking bench for burst
module tb_burst;

    logic clk = 1'b0;
    logic rst_n;
    logic b_a, b_b, b_c;
    logic clk_a, busy_a, clk_b, busy_b, clk_c, busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    burst #(10, 1, 1) dut_a (.clk(clk), .rst_n(rst_n), .bRelease(b_a), .burstClk(clk_a), .busy(busy_a));
    burst #(3, 2, 3)  dut_b (.clk(clk), .rst_n(rst_n), .bRelease(b_b), .burstClk(clk_b), .busy(busy_b));
    burst #(0, 1, 1)  dut_c (.clk(clk), .rst_n(rst_n), .bRelease(b_c), .burstClk(clk_c), .busy(busy_c));

    task automatic compare(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Wait one cycle, then compare the selected instance's outputs at the falling edge.
    task automatic cyc(input int sel, input logic e_clk, input logic e_busy, input string tag);
        logic o_clk, o_busy;
        @(negedge clk);
        case (sel)
            0:       begin o_clk = clk_a; o_busy = busy_a; end
            1:       begin o_clk = clk_b; o_busy = busy_b; end
            default: begin o_clk = clk_c; o_busy = busy_c; end
        endcase
        compare({tag, ".burstClk"}, o_clk, e_clk);
        compare({tag, ".busy"}, o_busy, e_busy);
    endtask

    // Trigger was applied just after a falling edge: two quiet cycles, then the pulse train.
    // toggle_at drops b_a for one cycle at that burst cycle; stop_at ends the check early.
    task automatic check_burst(input int sel, input int p, input int h, input int l,
                               input int toggle_at, input int stop_at, input string tag);
        int total;
        total = p * (h + l);
        cyc(sel, 1'b0, 1'b0, {tag, ".lat1"});
        cyc(sel, 1'b0, 1'b0, {tag, ".lat2"});
        for (int i = 0; i < total; i++) begin
            if (stop_at >= 0 && i == stop_at) return;
            if (i == toggle_at)     b_a = 1'b0;
            if (i == toggle_at + 1) b_a = 1'b1;
            cyc(sel, ((i % (h + l)) < h), 1'b1, $sformatf("%s.c%0d", tag, i));
        end
        for (int i = 0; i < 6; i++) cyc(sel, 1'b0, 1'b0, $sformatf("%s.idle%0d", tag, i));
    endtask

    initial begin
        rst_n = 1'b0;
        b_a = 1'b0;
        b_b = 1'b0;
        b_c = 1'b0;
        cyc(0, 1'b0, 1'b0, "rst_a");
        cyc(1, 1'b0, 1'b0, "rst_b");
        cyc(2, 1'b0, 1'b0, "rst_c");
        rst_n = 1'b1;
        cyc(0, 1'b0, 1'b0, "post_rst");
        cyc(0, 1'b0, 1'b0, "post_rst2");

        // Default burst, trigger held high afterwards
        b_a = 1'b1;
        check_burst(0, 10, 1, 1, -10, -1, "first");

        // Re-arm and retrigger during pulse 4
        b_a = 1'b0;
        cyc(0, 1'b0, 1'b0, "rearm_low1");
        cyc(0, 1'b0, 1'b0, "rearm_low2");
        cyc(0, 1'b0, 1'b0, "rearm_low3");
        b_a = 1'b1;
        check_burst(0, 10, 1, 1, 6, -1, "retrig");

        // Plain re-arm after idle
        b_a = 1'b0;
        cyc(0, 1'b0, 1'b0, "rearm2_low1");
        cyc(0, 1'b0, 1'b0, "rearm2_low2");
        cyc(0, 1'b0, 1'b0, "rearm2_low3");
        b_a = 1'b1;
        check_burst(0, 10, 1, 1, -10, -1, "rearm");

        // Reset mid-burst during pulse 5 with trigger still high
        b_a = 1'b0;
        cyc(0, 1'b0, 1'b0, "mid_low1");
        cyc(0, 1'b0, 1'b0, "mid_low2");
        cyc(0, 1'b0, 1'b0, "mid_low3");
        b_a = 1'b1;
        check_burst(0, 10, 1, 1, -10, 9, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        compare("async_rst.burstClk", clk_a, 1'b0);
        compare("async_rst.busy", busy_a, 1'b0);
        cyc(0, 1'b0, 1'b0, "in_rst");
        rst_n = 1'b1;
        check_burst(0, 10, 1, 1, -10, -1, "after_rst");

        // Alternate parameters (3,2,3)
        b_b = 1'b1;
        check_burst(1, 3, 2, 3, -10, -1, "p323");

        // Disabled instance ignores edges
        b_c = 1'b1;
        for (int i = 0; i < 8; i++) cyc(2, 1'b0, 1'b0, $sformatf("p0_a%0d", i));
        b_c = 1'b0;
        cyc(2, 1'b0, 1'b0, "p0_low");
        cyc(2, 1'b0, 1'b0, "p0_low2");
        b_c = 1'b1;
        for (int i = 0; i < 8; i++) cyc(2, 1'b0, 1'b0, $sformatf("p0_b%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
